uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Turns the XOR of the data bits into the parity bit for the chosen mode.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty are
// distinguished without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // A write while full is dropped even if a pop frees a slot this cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
  end

  // Pointers reset to empty; the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: words queue in sync_fifo and are
// serialised start / data (LSB first) / optional parity / stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 tx_ready,
  output logic                 tx_status,
  output logic                 tx_overflow,
  output logic                 uart_tx
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_status_q, tx_status_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (sysclk),
    .reset    (reset),
    .push     (tx_en),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bit_end     = (baud_cnt_q == CNT_LAST);
  assign tx_ready    = ~fifo_full;
  assign tx_status   = tx_status_q;
  assign tx_overflow = overflow_q;
  assign uart_tx     = uart_tx_q;

  // Next-state logic: loads a word from the FIFO when idle or at the end of
  // the last stop bit, and steps through the frame one bit period at a time.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : (baud_cnt_q + 1'b1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    fifo_pop   = 1'b0;
    uart_tx_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          parity_d = parity_bit(^fifo_rd_data, PARITY);
          state_d  = ST_START;
        end
      end
      ST_START: begin
        uart_tx_d = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        uart_tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        uart_tx_d = parity_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        uart_tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rd_data;
              parity_d = parity_bit(^fifo_rd_data, PARITY);
              state_d  = ST_START;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_status_d = (state_q == ST_IDLE) && fifo_empty && !tx_en;
    overflow_d  = overflow_q | (tx_en & fifo_full);
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      uart_tx_q   <= 1'b1;
      tx_status_q <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      uart_tx_q   <= uart_tx_d;
      tx_status_q <= tx_status_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 8E1, 8O1 and 7E2 instances at
// CLK_DIV=4, with line waveforms checked cycle by cycle.
module tb_uart_tx_fifo;

  logic sysclk;
  logic reset;

  logic [7:0] data_a, data_e, data_o;
  logic [6:0] data_s;
  logic en_a, en_e, en_o, en_s;
  logic ready_a, ready_e, ready_o, ready_s;
  logic status_a, status_e, status_o, status_s;
  logic ovf_a, ovf_e, ovf_o, ovf_s;
  logic line_a, line_e, line_o, line_s;

  int checks;
  int errors;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
    .sysclk(sysclk), .reset(reset), .tx_data(data_a), .tx_en(en_a),
    .tx_ready(ready_a), .tx_status(status_a), .tx_overflow(ovf_a), .uart_tx(line_a));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) dut_e (
    .sysclk(sysclk), .reset(reset), .tx_data(data_e), .tx_en(en_e),
    .tx_ready(ready_e), .tx_status(status_e), .tx_overflow(ovf_e), .uart_tx(line_e));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut_o (
    .sysclk(sysclk), .reset(reset), .tx_data(data_o), .tx_en(en_o),
    .tx_ready(ready_o), .tx_status(status_o), .tx_overflow(ovf_o), .uart_tx(line_o));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) dut_s (
    .sysclk(sysclk), .reset(reset), .tx_data(data_s), .tx_en(en_s),
    .tx_ready(ready_s), .tx_status(status_s), .tx_overflow(ovf_s), .uart_tx(line_s));

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Expected line level rel cycles after a frame's start bit first appears;
  // bits holds the frame LSB first (start bit at index 0).
  function automatic logic exp_line(input logic [15:0] bits, input int nbits, input int rel);
    if (rel < 0 || rel >= 4 * nbits) return 1'b1;
    return bits[rel / 4];
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (line_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_line_a got %b exp 1", line_a); end
    checks++; if (status_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_status_a got %b exp 1", status_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_a got %b exp 1", ready_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf_a got %b exp 0", ovf_a); end
    checks++; if ({line_e, line_o, line_s} !== 3'b111) begin errors++; $display("[TB] FAIL reset_lines got %b exp 111", {line_e, line_o, line_s}); end
    checks++; if ({status_e, status_o, status_s} !== 3'b111) begin errors++; $display("[TB] FAIL reset_status got %b exp 111", {status_e, status_o, status_s}); end
    reset = 1'b0;
    tick();
  endtask

  // 8N1 0xA5: start low at cycles 2-5, idle again at cycle 42.
  task automatic test_single_frame();
    logic exp;
    logic exp_st;
    data_a = 8'hA5;
    en_a   = 1'b1;
    tick();
    en_a   = 1'b0;
    data_a = 8'hFF;
    for (int c = 0; c < 46; c++) begin
      exp    = exp_line(16'h034A, 10, c - 2);
      exp_st = (c >= 42);
      checks++; if (line_a !== exp) begin errors++; $display("[TB] FAIL single_line c=%0d got %b exp %b", c, line_a, exp); end
      checks++; if (status_a !== exp_st) begin errors++; $display("[TB] FAIL single_status c=%0d got %b exp %b", c, status_a, exp_st); end
      tick();
    end
  endtask

  // 0x07 with even (parity 1) and odd (parity 0); 7E2 0x4B is 44 cycles.
  task automatic test_parity();
    logic exp_e, exp_o, exp_s, exp_st;
    data_e = 8'h07; data_o = 8'h07; data_s = 7'h4B;
    en_e = 1'b1; en_o = 1'b1; en_s = 1'b1;
    tick();
    en_e = 1'b0; en_o = 1'b0; en_s = 1'b0;
    for (int c = 0; c < 50; c++) begin
      exp_e  = exp_line(16'h060E, 11, c - 2);
      exp_o  = exp_line(16'h040E, 11, c - 2);
      exp_s  = exp_line(16'h0696, 11, c - 2);
      exp_st = (c >= 46);
      checks++; if (line_e !== exp_e) begin errors++; $display("[TB] FAIL even_line c=%0d got %b exp %b", c, line_e, exp_e); end
      checks++; if (line_o !== exp_o) begin errors++; $display("[TB] FAIL odd_line c=%0d got %b exp %b", c, line_o, exp_o); end
      checks++; if (line_s !== exp_s) begin errors++; $display("[TB] FAIL 7e2_line c=%0d got %b exp %b", c, line_s, exp_s); end
      checks++; if (status_s !== exp_st) begin errors++; $display("[TB] FAIL 7e2_status c=%0d got %b exp %b", c, status_s, exp_st); end
      tick();
    end
  endtask

  // Six writes into a depth-4 FIFO: five frames back to back, sixth dropped.
  task automatic test_overflow();
    logic [15:0] frames [5];
    logic exp, exp_rdy, exp_ovf, exp_st;
    int rel;
    frames = '{16'h0222, 16'h0224, 16'h0226, 16'h0228, 16'h022A};
    for (int k = 0; k < 6; k++) begin
      data_a = 8'h11 + 8'(k);
      en_a   = 1'b1;
      tick();
      exp_rdy = (k < 4);
      exp_ovf = (k == 5);
      checks++; if (ready_a !== exp_rdy) begin errors++; $display("[TB] FAIL ovf_ready k=%0d got %b exp %b", k, ready_a, exp_rdy); end
      checks++; if (ovf_a !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_flag k=%0d got %b exp %b", k, ovf_a, exp_ovf); end
    end
    en_a = 1'b0;
    for (int c = 5; c < 206; c++) begin
      rel = c - 2;
      if (rel < 0 || rel >= 200) exp = 1'b1;
      else exp = exp_line(frames[rel / 40], 10, rel % 40);
      exp_st = (c >= 202);
      checks++; if (line_a !== exp) begin errors++; $display("[TB] FAIL ovf_line c=%0d got %b exp %b", c, line_a, exp); end
      checks++; if (status_a !== exp_st) begin errors++; $display("[TB] FAIL ovf_status c=%0d got %b exp %b", c, status_a, exp_st); end
      tick();
    end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp 1", ovf_a); end
  endtask

  // A word written during the stop bit starts right after it.
  task automatic test_stop_write();
    logic exp, exp_st;
    data_a = 8'h5A;
    en_a   = 1'b1;
    tick();
    en_a   = 1'b0;
    for (int c = 0; c < 86; c++) begin
      if (c < 42) exp = exp_line(16'h02B4, 10, c - 2);
      else exp = exp_line(16'h0386, 10, c - 42);
      exp_st = (c >= 82);
      checks++; if (line_a !== exp) begin errors++; $display("[TB] FAIL stopwr_line c=%0d got %b exp %b", c, line_a, exp); end
      checks++; if (status_a !== exp_st) begin errors++; $display("[TB] FAIL stopwr_status c=%0d got %b exp %b", c, status_a, exp_st); end
      if (c == 38) begin data_a = 8'hC3; en_a = 1'b1; end
      if (c == 39) begin en_a = 1'b0; data_a = 8'h00; end
      tick();
    end
  endtask

  // Reset during the third data bit, with a write in the reset cycle.
  task automatic test_mid_reset();
    logic exp, exp_st;
    data_a = 8'h96;
    en_a   = 1'b1;
    tick();
    en_a   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp = exp_line(16'h032C, 10, c - 2);
      checks++; if (line_a !== exp) begin errors++; $display("[TB] FAIL rst_pre_line c=%0d got %b exp %b", c, line_a, exp); end
      if (c < 15) tick();
    end
    reset  = 1'b1;
    en_a   = 1'b1;
    data_a = 8'hFF;
    tick();
    en_a   = 1'b0;
    reset  = 1'b0;
    checks++; if (line_a !== 1'b1) begin errors++; $display("[TB] FAIL rst_line got %b exp 1", line_a); end
    checks++; if (status_a !== 1'b1) begin errors++; $display("[TB] FAIL rst_status got %b exp 1", status_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b exp 1", ready_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got %b exp 0", ovf_a); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if ({line_a, status_a} !== 2'b11) begin errors++; $display("[TB] FAIL rst_quiet c=%0d got %b exp 11", c, {line_a, status_a}); end
    end
    data_a = 8'h3C;
    en_a   = 1'b1;
    tick();
    en_a   = 1'b0;
    for (int c = 0; c < 46; c++) begin
      exp    = exp_line(16'h0278, 10, c - 2);
      exp_st = (c >= 42);
      checks++; if (line_a !== exp) begin errors++; $display("[TB] FAIL rst_post_line c=%0d got %b exp %b", c, line_a, exp); end
      checks++; if (status_a !== exp_st) begin errors++; $display("[TB] FAIL rst_post_status c=%0d got %b exp %b", c, status_a, exp_st); end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en_a = 1'b0; en_e = 1'b0; en_o = 1'b0; en_s = 1'b0;
    data_a = '0; data_e = '0; data_o = '0; data_s = '0;
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_stop_write();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
